// File: rtl/ram8_loader_pkg.sv
// Shared constants and FSM state encoding for the RAM8 burst loader.
package ram8_loader_pkg;
    localparam int unsigned WIDTH_DEF  = 16;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned DEPTH      = 8;

    typedef enum logic [1:0] {IDLE, LOAD, DUMP, FIN} ldr_state_t;
endpackage

// File: rtl/ram8_loader.sv
// Burst sequencer in front of RAM8: LOAD streams source words into consecutive
// addresses, DUMP streams consecutive words out to a sink; bursts of 0..8 words.
module ram8_loader
    import ram8_loader_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_load,
    input  logic              start_dump,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    input  logic [WIDTH-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  ram_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ld,
    input  logic [WIDTH-1:0]  ram_out,
    output logic              busy,
    output logic              done
);

    // Full depth expressed in the count width, used to clamp oversize requests.
    localparam logic [ADDR_W:0] MAXCNT = {1'b1, {ADDR_W{1'b0}}};

    ldr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   count_clamped;

    assign count_clamped = (count > MAXCNT) ? MAXCNT : count;
    assign m_data        = ram_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            remain_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            remain_q <= remain_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        remain_d = remain_q;
        idx_d    = idx_q;
        s_ready  = 1'b0;
        m_valid  = 1'b0;
        ram_ld   = 1'b0;
        ram_in   = '0;
        ram_addr = base_q;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_load || start_dump) begin
                    base_d   = base;
                    remain_d = count_clamped;
                    idx_d    = '0;
                    if (count_clamped == '0) begin
                        state_d = FIN;
                    end else if (start_load) begin
                        state_d = LOAD;
                    end else begin
                        state_d = DUMP;
                    end
                end
            end
            LOAD: begin
                busy     = 1'b1;
                s_ready  = 1'b1;
                ram_addr = base_q + idx_q;
                ram_in   = s_data;
                ram_ld   = s_valid;
                if (s_valid) begin
                    idx_d    = idx_q + ADDR_W'(1);
                    remain_d = remain_q - (ADDR_W+1)'(1);
                    if (remain_q == (ADDR_W+1)'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            DUMP: begin
                busy     = 1'b1;
                m_valid  = 1'b1;
                ram_addr = base_q + idx_q;
                if (m_ready) begin
                    idx_d    = idx_q + ADDR_W'(1);
                    remain_d = remain_q - (ADDR_W+1)'(1);
                    if (remain_q == (ADDR_W+1)'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram8_loader.sv
// Self-checking bench: ram8_loader driving a behavioural RAM8, expected
// writes/reads queued on stimulus and popped as the loader transfers words.
module tb_ram8_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_load, start_dump;
    logic [2:0]  base;
    logic [3:0]  count;
    logic [15:0] s_data;
    logic        s_valid, s_ready;
    logic [15:0] m_data;
    logic        m_valid, m_ready;
    logic [15:0] ram_in, ram_out;
    logic [2:0]  ram_addr;
    logic        ram_ld;
    logic        busy, done;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } xact_t;

    xact_t       exp_q[$];
    logic [15:0] model [8];
    logic [15:0] mem   [8];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural RAM8: combinational read, write on the clock edge while ld=1.
    always @(posedge clk) begin
        if (ram_ld) mem[ram_addr] <= ram_in;
    end
    assign ram_out = mem[ram_addr];

    ram8_loader #(.WIDTH(16), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .start_load(start_load), .start_dump(start_dump),
        .base(base), .count(count),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .ram_in(ram_in), .ram_addr(ram_addr), .ram_ld(ram_ld),
        .ram_out(ram_out), .busy(busy), .done(done)
    );

    task automatic test_reset();
        reset = 1'b1; start_load = 1'b0; start_dump = 1'b0;
        base = 3'd5; count = 4'd3; s_data = 16'hFFFF; s_valid = 1'b1; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({s_ready, m_valid, ram_ld, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {s_ready, m_valid, ram_ld, busy, done});
        end
        n_checks++;
        if (ram_addr !== 3'd0 || ram_in !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr %0d in %h expected addr 0 in 0000", ram_addr, ram_in);
        end
        reset = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    // One LOAD or DUMP burst. pat/plen give the per-cycle valid (LOAD) or
    // ready (DUMP) pattern, 1 after the pattern ends; poke_at pulses start_dump.
    task automatic run_burst(input bit is_load, input bit both, input logic [2:0] b,
                             input logic [3:0] c, input logic [15:0] d0,
                             input logic [15:0] pat, input int plen, input int poke_at);
        int    n, sent, last_hs, done_idx, ndone;
        bit    hs_en;
        xact_t x;
        n = (c > 4'd8) ? 8 : int'(c);
        for (int i = 0; i < n; i++) begin
            x.a = b + 3'(i);
            if (is_load) begin
                x.d = d0 + 16'(i);
                model[x.a] = x.d;
            end else begin
                x.d = model[x.a];
            end
            exp_q.push_back(x);
        end

        @(posedge clk); #1;
        start_load = is_load || both;
        start_dump = !is_load || both;
        base = b; count = c; s_valid = 1'b0; m_ready = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || ram_ld !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_idle: got busy %b ld %b mvalid %b expected 0 0 0", busy, ram_ld, m_valid);
        end
        @(posedge clk); #1;
        start_load = 1'b0; start_dump = 1'b0;
        base = 3'd0; count = 4'd0;

        sent = 0; last_hs = -1; done_idx = -1; ndone = 0;
        for (int k = 0; k < 3 * n + 8 && (done_idx < 0 || k <= done_idx + 2); k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            hs_en      = (k < plen) ? pat[k] : 1'b1;
            s_valid    = is_load && hs_en;
            m_ready    = !is_load && hs_en;
            s_data     = d0 + 16'(sent);
            start_dump = (k == poke_at);
            #1;
            if (ram_ld) begin
                n_checks++;
                if (!is_load || exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_ld: got ram_ld 1 at cycle %0d expected 0", k);
                end else begin
                    x = exp_q.pop_front();
                    if (ram_addr !== x.a || ram_in !== x.d) begin
                        n_fail++;
                        $display("FAIL load_write: got addr %0d data %h expected addr %0d data %h",
                                 ram_addr, ram_in, x.a, x.d);
                    end
                end
            end
            if (m_valid) begin
                n_checks++;
                if (is_load || exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_mvalid: got m_valid 1 at cycle %0d expected 0", k);
                end else begin
                    x = exp_q[0];
                    if (ram_addr !== x.a || m_data !== x.d) begin
                        n_fail++;
                        $display("FAIL dump_word: got addr %0d data %h expected addr %0d data %h",
                                 ram_addr, m_data, x.a, x.d);
                    end
                    if (m_ready) void'(exp_q.pop_front());
                end
            end
            if (s_ready && !is_load) begin
                n_checks++; n_fail++;
                $display("FAIL spurious_sready: got s_ready 1 at cycle %0d expected 0", k);
            end
            if (is_load ? (s_valid && s_ready) : (m_valid && m_ready)) begin
                last_hs = k;
                sent++;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) done_idx = k;
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_at_done: got %b expected 0", busy);
                end
            end
            if (done_idx >= 0 && k > done_idx) begin
                n_checks++;
                if (busy !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL post_idle: got busy %b sready %b mvalid %b expected 0 0 0",
                             busy, s_ready, m_valid);
                end
            end
        end
        s_valid = 1'b0; m_ready = 1'b0; start_dump = 1'b0;

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL transfers_left: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL done_count: got %0d expected 1", ndone);
        end
        n_checks++;
        if (done_idx != last_hs + 1) begin
            n_fail++;
            $display("FAIL done_timing: got cycle %0d expected %0d", done_idx, last_hs + 1);
        end
        if (plen == 0) begin
            n_checks++;
            if (done_idx != n) begin
                n_fail++;
                $display("FAIL burst_length: got done at %0d expected %0d", done_idx, n);
            end
        end
    endtask

    task automatic test_load_full();
        run_burst(1'b1, 1'b0, 3'd0, 4'd8, 16'h1000, 16'h0, 0, -1);
        run_burst(1'b0, 1'b0, 3'd0, 4'd8, 16'h0, 16'h0, 0, -1);
    endtask

    task automatic test_wrap();
        run_burst(1'b1, 1'b0, 3'd6, 4'd4, 16'h00A0, 16'h0, 0, -1);
        run_burst(1'b0, 1'b0, 3'd0, 4'd8, 16'h0, 16'h0, 0, -1);
        // gapped source: valid pattern 1,0,1,1,0,1
        run_burst(1'b1, 1'b0, 3'd2, 4'd4, 16'h0B00, 16'b10_1101, 6, -1);
        run_burst(1'b0, 1'b0, 3'd0, 4'd8, 16'h0, 16'h0, 0, -1);
    endtask

    task automatic test_dump_stall();
        // ready pattern 1,0,0,1,1
        run_burst(1'b0, 1'b0, 3'd5, 4'd3, 16'h0, 16'b1_1001, 5, -1);
    endtask

    task automatic test_priority();
        run_burst(1'b1, 1'b1, 3'd2, 4'd2, 16'h2200, 16'h0, 0, -1);
        run_burst(1'b0, 1'b0, 3'd1, 4'd3, 16'h0, 16'h0, 0, -1);
    endtask

    task automatic test_back_to_back_ignore();
        run_burst(1'b1, 1'b0, 3'd3, 4'd3, 16'h3300, 16'h0, 0, 1);
        run_burst(1'b0, 1'b0, 3'd3, 4'd3, 16'h0, 16'h0, 0, -1);
    endtask

    task automatic test_count_edges();
        run_burst(1'b1, 1'b0, 3'd1, 4'd0, 16'h7700, 16'h0, 0, -1);
        run_burst(1'b0, 1'b0, 3'd4, 4'd0, 16'h0, 16'h0, 0, -1);
        run_burst(1'b1, 1'b0, 3'd0, 4'd12, 16'h4000, 16'h0, 0, -1);
        run_burst(1'b0, 1'b0, 3'd0, 4'd15, 16'h0, 16'h0, 0, -1);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start_load = 1'b1; base = 3'd4; count = 4'd6; s_valid = 1'b0;
        @(posedge clk); #1;
        start_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 16'h5000 + 16'(k);
            model[3'd4 + 3'(k)] = 16'h5000 + 16'(k);
            #1;
            n_checks++;
            if (ram_ld !== 1'b1 || ram_addr !== 3'd4 + 3'(k)) begin
                n_fail++;
                $display("FAIL mid_write: got ld %b addr %0d expected ld 1 addr %0d",
                         ram_ld, ram_addr, 3'd4 + 3'(k));
            end
            @(posedge clk); #1;
        end
        reset = 1'b1; s_data = 16'h5003;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if ({s_ready, m_valid, ram_ld, busy, done} !== 5'b0 || ram_addr !== 3'd0 || ram_in !== 16'h0) begin
                n_fail++;
                $display("FAIL after_reset: got ctrl %b addr %0d in %h expected 00000 addr 0 in 0000",
                         {s_ready, m_valid, ram_ld, busy, done}, ram_addr, ram_in);
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        run_burst(1'b0, 1'b0, 3'd4, 4'd3, 16'h0, 16'h0, 0, -1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            model[i] = 16'h0;
            mem[i]   = 16'h0;
        end
        test_reset();
        test_load_full();
        test_wrap();
        test_dump_stall();
        test_priority();
        test_back_to_back_ignore();
        test_count_edges();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
